pong_game_fsm: RTL and testbench
================================

# pong_game_fsm

Synchronous game-flow controller for the pong display pipeline. It sequences the menu, score-limit setup, serve, play, point-pause and game-over phases, and owns both player scores, the score limit, the winner and the serving side. The ball/paddle datapath and the renderer consume its Moore outputs; the ball datapath returns wall-miss pulses. It replaces ad-hoc gated-clock state logic with a single clocked FSM on `clk_pix`.

## Interface
Parameters:
- `SCORE_W`, 5: width of the score and score-limit registers.
- `MAX_SCORE_INIT`, 5: score limit loaded at reset.
- `PAUSE_FRAMES`, 60: number of `frame_tick` pulses spent in END_POINT.
- `SERVE_FRAMES`, 120: auto-serve delay, counted in `frame_tick` pulses (used only with `PONG_AUTO_SERVE_EN`).

Ports:
- `clk_pix` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame at (x=0, y=480).
- `btn_launch` in 1: launch/confirm button level, already synchronized.
- `btn_up` in 1: score-limit increment button level, already synchronized.
- `btn_down` in 1: score-limit decrement button level, already synchronized.
- `left_miss` in 1: one-cycle pulse; ball reached the left wall.
- `right_miss` in 1: one-cycle pulse; ball reached the right wall.
- `state` out 3: MENU=0, SET=1, START=2, PLAY=3, END_POINT=4, END_GAME=5.
- `ball_load` out 1: high in START; datapath holds the ball at the serve position.
- `move_en` out 1: high in PLAY only; enables ball motion.
- `serve_side` out 1: 0 = ball serves from P1 (left), 1 = from P2 (right).
- `score_p1`, `score_p2` out SCORE_W: player scores.
- `max_score` out SCORE_W: current score limit.
- `winner` out 2: 0 = none, 1 = P1, 2 = P2.

## Operation
- Edge detect: `btn_launch`, `btn_up` and `btn_down` each have a registered previous sample. Rise = level & ~prev. Only rises act.
- MENU: a launch rise moves the FSM to SET.
- SET:
  - An up rise increments `max_score`, saturating at 2^SCORE_W−1.
  - A down rise decrements `max_score`, saturating at 1.
  - Up and down rising in the same cycle leave `max_score` unchanged.
  - A launch rise moves to START and clears both scores, `winner` and `serve_side`.
- START: `ball_load`=1. A launch rise moves to PLAY.
- PLAY: `move_en`=1.
  - `left_miss`: `score_p2`+1, `serve_side`←0, go to END_POINT.
  - `right_miss`: `score_p1`+1, `serve_side`←1, go to END_POINT.
  - Both in the same cycle: `left_miss` wins and `right_miss` is dropped.
- END_POINT:
  - The pause counter clears on entry and increments on each `frame_tick`.
  - When the count reaches PAUSE_FRAMES: if `score_p1`==`max_score`, set `winner`=1 and go to END_GAME.
  - Otherwise, if `score_p2`==`max_score`, set `winner`=2 and go to END_GAME.
  - Otherwise go to START.
- END_GAME: scores and `winner` are held for display. A launch rise moves to MENU. `max_score` is retained.
- Miss pulses outside PLAY are ignored. Button rises in states that do not use them are ignored.
- Illegal state encodings (6, 7) go to MENU on the next cycle.
- Score increments never wrap, because END_GAME is always reached at `max_score` ≤ 2^SCORE_W−1.

## Timing
- All registers update on the rising edge of `clk_pix`. `reset` has priority over every other input.
- Reset values: `state`=MENU, scores=0, `max_score`=MAX_SCORE_INIT, `winner`=0, `serve_side`=0, counters=0, edge-detect registers=0.
- Outputs are Moore, decoded from the state register. A qualifying input in cycle n produces the new state and outputs in cycle n+1.
- A score increment and entry to END_POINT occur on the same edge.
- A `frame_tick` in the entry cycle of END_POINT is not counted.
- END_POINT exits on the edge after the PAUSE_FRAMES-th counted tick.
- Asserting `reset` mid-game returns to MENU on the next edge and discards the scores.

## Configuration
- `PONG_AUTO_SERVE_EN` defined:
  - START keeps a serve counter that clears on entry and increments on each `frame_tick`.
  - After SERVE_FRAMES ticks the FSM enters PLAY without a button press.
  - A launch rise before that still serves immediately.
- Undefined: the serve counter is not built, and START leaves only on a launch rise.

## Test plan
- Reset, then launch rise, 3 up rises, 1 down rise, launch rise → `max_score`=7, `state`=START, scores 0.
- In SET with `max_score`=31, up rise → `max_score` stays 31. With `max_score`=1, down rise → stays 1.
- In PLAY, `left_miss` and `right_miss` in the same cycle → `score_p2`=1, `score_p1`=0, `serve_side`=0, `state`=END_POINT next cycle.
- With `max_score`=2 and `score_p1`=1, a `right_miss` then PAUSE_FRAMES frame ticks → `winner`=1 and `state`=END_GAME; a launch rise then gives MENU.
- `btn_launch` held high for 1000 cycles in MENU → exactly one transition (to SET). A mid-PLAY `reset` pulse → MENU with scores 0.
- With `PONG_AUTO_SERVE_EN`: in START with no buttons, SERVE_FRAMES ticks → PLAY. Without the macro, the same stimulus leaves the FSM in START.

Source files
------------

// File: rtl/pong_game_fsm.sv
// -----------------------------------------------------------------------------
// pong_game_fsm
//
// Game-flow controller for the pong display pipeline. A single clocked FSM on
// clk_pix sequences MENU -> SET -> START -> PLAY -> END_POINT -> (START |
// END_GAME) -> MENU. It owns both player scores, the score limit, the winner
// and the serving side. All outputs are Moore, decoded from registers.
//
// Optional feature macro: PONG_AUTO_SERVE_EN
//   defined   : START also leaves for PLAY after SERVE_FRAMES frame ticks.
//   undefined : START leaves only on a launch rise.
//
// Handshake: there is no valid/ready traffic here. Every input is either a
// synchronized level (buttons, edge-detected internally) or a one-cycle pulse
// (frame_tick, left_miss, right_miss). A qualifying input in cycle n is seen
// in the state and outputs of cycle n+1.
//
// Ports
//   clk_pix     in   pixel clock, the only clock
//   reset       in   synchronous, active-high
//   frame_tick  in   one pulse per frame
//   btn_launch  in   launch/confirm level
//   btn_up      in   score-limit increment level
//   btn_down    in   score-limit decrement level
//   left_miss   in   pulse: ball reached the left wall
//   right_miss  in   pulse: ball reached the right wall
//   state       out  MENU=0 SET=1 START=2 PLAY=3 END_POINT=4 END_GAME=5
//   ball_load   out  high in START
//   move_en     out  high in PLAY
//   serve_side  out  0 = serve from P1 (left), 1 = from P2 (right)
//   score_p1    out  player 1 score
//   score_p2    out  player 2 score
//   max_score   out  current score limit
//   winner      out  0 none, 1 P1, 2 P2
// -----------------------------------------------------------------------------
module pong_game_fsm #(
  parameter int SCORE_W        = 5,
  parameter int MAX_SCORE_INIT = 5,
  parameter int PAUSE_FRAMES   = 60,
  parameter int SERVE_FRAMES   = 120
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_launch,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               left_miss,
  input  logic               right_miss,
  output logic [2:0]         state,
  output logic               ball_load,
  output logic               move_en,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [SCORE_W-1:0] max_score,
  output logic [1:0]         winner
);

  // One frame counter is shared by the END_POINT pause and the START
  // auto-serve delay; the two states never overlap, so it is sized for the
  // larger of the two limits.
  localparam int CNT_MAX = (PAUSE_FRAMES > SERVE_FRAMES) ? PAUSE_FRAMES : SERVE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_SET       = 3'd1,
    S_START     = 3'd2,
    S_PLAY      = 3'd3,
    S_END_POINT = 3'd4,
    S_END_GAME  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic               r_launch_prev;
  logic               r_up_prev;
  logic               r_down_prev;
  logic               w_launch_rise;
  logic               w_up_rise;
  logic               w_down_rise;

  logic [SCORE_W-1:0] r_score_p1;
  logic [SCORE_W-1:0] r_score_p2;
  logic [SCORE_W-1:0] r_max_score;
  logic [1:0]         r_winner;
  logic               r_serve_side;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_ep_first;

  // Datapath controls produced by the next-state logic.
  logic               w_clear_game;
  logic               w_inc_p1;
  logic               w_inc_p2;
  logic               w_serve_load;
  logic               w_serve_val;
  logic               w_winner_load;
  logic [1:0]         w_winner_val;
  logic               w_max_inc;
  logic               w_max_dec;
  logic               w_cnt_inc;

  assign w_launch_rise = btn_launch & ~r_launch_prev;
  assign w_up_rise     = btn_up     & ~r_up_prev;
  assign w_down_rise   = btn_down   & ~r_down_prev;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state <= S_MENU;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_clear_game  = 1'b0;
    w_inc_p1      = 1'b0;
    w_inc_p2      = 1'b0;
    w_serve_load  = 1'b0;
    w_serve_val   = 1'b0;
    w_winner_load = 1'b0;
    w_winner_val  = 2'd0;
    w_max_inc     = 1'b0;
    w_max_dec     = 1'b0;
    w_cnt_inc     = 1'b0;

    case (r_state)
      S_MENU: begin
        if (w_launch_rise) begin
          w_next_state = S_SET;
        end
      end

      S_SET: begin
        // Simultaneous up and down rises cancel out.
        if (w_up_rise && !w_down_rise && (r_max_score != SCORE_TOP)) begin
          w_max_inc = 1'b1;
        end
        if (w_down_rise && !w_up_rise && (r_max_score > SCORE_ONE)) begin
          w_max_dec = 1'b1;
        end
        if (w_launch_rise) begin
          w_clear_game = 1'b1;
          w_next_state = S_START;
        end
      end

      S_START: begin
`ifdef PONG_AUTO_SERVE_EN
        if (w_launch_rise) begin
          w_next_state = S_PLAY;
        end else if (frame_tick) begin
          w_cnt_inc = 1'b1;
          if (r_frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            w_next_state = S_PLAY;
          end
        end
`else
        if (w_launch_rise) begin
          w_next_state = S_PLAY;
        end
`endif
      end

      S_PLAY: begin
        // left_miss has priority; a coincident right_miss is dropped.
        if (left_miss) begin
          w_inc_p2     = 1'b1;
          w_serve_load = 1'b1;
          w_serve_val  = 1'b0;
          w_next_state = S_END_POINT;
        end else if (right_miss) begin
          w_inc_p1     = 1'b1;
          w_serve_load = 1'b1;
          w_serve_val  = 1'b1;
          w_next_state = S_END_POINT;
        end
      end

      S_END_POINT: begin
        // A tick in the first END_POINT cycle is not counted. The pause ends
        // on the edge that registers the PAUSE_FRAMES-th counted tick.
        if (frame_tick && !r_ep_first) begin
          w_cnt_inc = 1'b1;
          if (r_frame_cnt == CNT_W'(PAUSE_FRAMES - 1)) begin
            if (r_score_p1 == r_max_score) begin
              w_winner_load = 1'b1;
              w_winner_val  = 2'd1;
              w_next_state  = S_END_GAME;
            end else if (r_score_p2 == r_max_score) begin
              w_winner_load = 1'b1;
              w_winner_val  = 2'd2;
              w_next_state  = S_END_GAME;
            end else begin
              w_next_state  = S_START;
            end
          end
        end
      end

      S_END_GAME: begin
        if (w_launch_rise) begin
          w_next_state = S_MENU;
        end
      end

      default: begin
        // Encodings 6 and 7 recover to MENU.
        w_next_state = S_MENU;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Game registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_launch_prev <= 1'b0;
      r_up_prev     <= 1'b0;
      r_down_prev   <= 1'b0;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_max_score   <= SCORE_W'(MAX_SCORE_INIT);
      r_winner      <= 2'd0;
      r_serve_side  <= 1'b0;
      r_frame_cnt   <= '0;
      r_ep_first    <= 1'b0;
    end else begin
      r_launch_prev <= btn_launch;
      r_up_prev     <= btn_up;
      r_down_prev   <= btn_down;

      if (w_clear_game) begin
        r_score_p1   <= '0;
        r_score_p2   <= '0;
        r_winner     <= 2'd0;
        r_serve_side <= 1'b0;
      end else begin
        if (w_inc_p1) begin
          r_score_p1 <= r_score_p1 + SCORE_ONE;
        end
        if (w_inc_p2) begin
          r_score_p2 <= r_score_p2 + SCORE_ONE;
        end
        if (w_serve_load) begin
          r_serve_side <= w_serve_val;
        end
        if (w_winner_load) begin
          r_winner <= w_winner_val;
        end
      end

      if (w_max_inc) begin
        r_max_score <= r_max_score + SCORE_ONE;
      end else if (w_max_dec) begin
        r_max_score <= r_max_score - SCORE_ONE;
      end

      // Any state change restarts the frame counter, which gives both the
      // pause and the serve delay a clean start on entry.
      if (w_next_state != r_state) begin
        r_frame_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end

      r_ep_first <= (w_next_state == S_END_POINT) && (r_state != S_END_POINT);
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  assign state      = r_state;
  assign ball_load  = (r_state == S_START);
  assign move_en    = (r_state == S_PLAY);
  assign serve_side = r_serve_side;
  assign score_p1   = r_score_p1;
  assign score_p2   = r_score_p2;
  assign max_score  = r_max_score;
  assign winner     = r_winner;

endmodule

// File: tb/tb_pong_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_pong_game_fsm
//
// Directed bench for pong_game_fsm. A game-level reference model advances on
// every rising clock edge from the same inputs; a compare process checks all
// DUT outputs against it on every falling edge. Literal checks at key points
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_pong_game_fsm;

  localparam int SCORE_W        = 5;
  localparam int MAX_SCORE_INIT = 5;
  localparam int PAUSE_FRAMES   = 60;
  localparam int SERVE_FRAMES   = 120;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk_pix = 1'b0;
  logic               reset   = 1'b1;
  logic               frame_tick = 1'b0;
  logic               btn_launch = 1'b0;
  logic               btn_up     = 1'b0;
  logic               btn_down   = 1'b0;
  logic               left_miss  = 1'b0;
  logic               right_miss = 1'b0;
  logic [2:0]         state;
  logic               ball_load;
  logic               move_en;
  logic               serve_side;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [SCORE_W-1:0] max_score;
  logic [1:0]         winner;

  always #5 clk_pix = ~clk_pix;

  pong_game_fsm #(
    .SCORE_W        (SCORE_W),
    .MAX_SCORE_INIT (MAX_SCORE_INIT),
    .PAUSE_FRAMES   (PAUSE_FRAMES),
    .SERVE_FRAMES   (SERVE_FRAMES)
  ) dut (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_launch (btn_launch),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .left_miss  (left_miss),
    .right_miss (right_miss),
    .state      (state),
    .ball_load  (ball_load),
    .move_en    (move_en),
    .serve_side (serve_side),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .max_score  (max_score),
    .winner     (winner)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: game rules expressed on plain integers
  // ---------------------------------------------------------------------------
  int m_phase  = 0;   // 0 menu,1 set,2 start,3 play,4 point pause,5 game over
  int m_p1     = 0;
  int m_p2     = 0;
  int m_limit  = MAX_SCORE_INIT;
  int m_win    = 0;
  int m_serve  = 0;
  int m_ticks  = 0;   // frames counted in the current pause / serve wait
  bit m_fresh  = 0;   // first cycle of a point pause
  bit m_pl = 0, m_pu = 0, m_pd = 0;

  always @(posedge clk_pix) begin
    bit lr, ur, dr;
    int prev_phase;
    lr = btn_launch && !m_pl;
    ur = btn_up && !m_pu;
    dr = btn_down && !m_pd;
    prev_phase = m_phase;
    if (reset) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_limit = MAX_SCORE_INIT;
      m_win = 0; m_serve = 0; m_ticks = 0; m_fresh = 0;
      m_pl = 0; m_pu = 0; m_pd = 0;
    end else begin
      m_pl = btn_launch; m_pu = btn_up; m_pd = btn_down;
      if (m_phase == 0) begin
        if (lr) m_phase = 1;
      end else if (m_phase == 1) begin
        if (ur && !dr && m_limit < 31) m_limit = m_limit + 1;
        if (dr && !ur && m_limit > 1)  m_limit = m_limit - 1;
        if (lr) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_serve = 0; m_phase = 2; m_ticks = 0;
        end
      end else if (m_phase == 2) begin
        if (lr) m_phase = 3;
`ifdef PONG_AUTO_SERVE_EN
        else if (frame_tick) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == SERVE_FRAMES) m_phase = 3;
        end
`endif
      end else if (m_phase == 3) begin
        if (left_miss) begin
          m_p2 = m_p2 + 1; m_serve = 0; m_phase = 4;
        end else if (right_miss) begin
          m_p1 = m_p1 + 1; m_serve = 1; m_phase = 4;
        end
      end else if (m_phase == 4) begin
        if (!m_fresh && frame_tick) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == PAUSE_FRAMES) begin
            if (m_p1 == m_limit)      begin m_win = 1; m_phase = 5; end
            else if (m_p2 == m_limit) begin m_win = 2; m_phase = 5; end
            else m_phase = 2;
          end
        end
      end else begin
        if (lr) m_phase = 0;
      end
      if (m_phase != prev_phase) m_ticks = 0;
      m_fresh = (m_phase == 4) && (prev_phase != 4);
    end
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge clk_pix) begin
    logic [22:0] got, exp;
    if (cmp_en) begin
      got = {state, ball_load, move_en, serve_side, score_p1, score_p2, max_score, winner};
      exp = {3'(m_phase), (m_phase == 2), (m_phase == 3), 1'(m_serve),
             5'(m_p1), 5'(m_p2), 5'(m_limit), 2'(m_win)};
      check("cycle_outputs", 32'(got), 32'(exp));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic press_launch();
    btn_launch = 1'b1; cyc(1); btn_launch = 1'b0; cyc(1);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      btn_up = 1'b1; cyc(1); btn_up = 1'b0; cyc(1);
    end
  endtask

  task automatic press_down(input int n);
    for (int i = 0; i < n; i++) begin
      btn_down = 1'b1; cyc(1); btn_down = 1'b0; cyc(1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    end
  endtask

  // Miss pulse followed by one idle cycle, so any later tick lands after the
  // first END_POINT cycle.
  task automatic miss(input bit left, input bit right);
    left_miss = left; right_miss = right; cyc(1);
    left_miss = 1'b0; right_miss = 1'b0; cyc(1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    cyc(3);
    reset = 1'b0;
    cmp_en = 1'b1;
    cyc(1);

    // Reset state
    check("reset_state", 32'(state), 0);
    check("reset_max", 32'(max_score), MAX_SCORE_INIT);
    check("reset_scores", 32'({score_p1, score_p2, winner, serve_side}), 0);

    // Menu -> set, 3 up, 1 down, launch -> START with limit 7
    press_launch();
    check("menu_to_set", 32'(state), 1);
    press_up(3);
    press_down(1);
    press_launch();
    check("set_limit_7", 32'(max_score), 7);
    check("set_to_start", 32'(state), 2);
    check("start_ball_load", 32'(ball_load), 1);
    press_launch();
    check("play_move_en", 32'({state, move_en}), 32'({3'd3, 1'b1}));

    // Simultaneous misses: left wins
    left_miss = 1'b1; right_miss = 1'b1; cyc(1);
    left_miss = 1'b0; right_miss = 1'b0;
    check("both_miss_state", 32'(state), 4);
    check("both_miss_scores", 32'({score_p1, score_p2, serve_side}), 32'({5'd0, 5'd1, 1'b0}));
    // Tick in the first END_POINT cycle is ignored
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    ticks(PAUSE_FRAMES - 1);
    check("pause_not_done", 32'(state), 4);
    ticks(1);
    check("pause_to_start", 32'(state), 2);

    // Limit saturation
    pulse_reset();
    check("reset_mid_game", 32'({state, max_score}), 32'({3'd0, 5'd5}));
    press_launch();
    press_up(26);
    check("limit_31", 32'(max_score), 31);
    press_up(1);
    check("limit_sat_high", 32'(max_score), 31);
    press_down(30);
    check("limit_1", 32'(max_score), 1);
    press_down(1);
    check("limit_sat_low", 32'(max_score), 1);
    btn_up = 1'b1; btn_down = 1'b1; cyc(1);
    btn_up = 1'b0; btn_down = 1'b0; cyc(1);
    check("limit_up_down", 32'(max_score), 1);
    press_up(1);
    press_launch();
    check("limit_2_start", 32'({state, max_score}), 32'({3'd2, 5'd2}));

    // P1 wins at limit 2
    press_launch();
    miss(1'b0, 1'b1);
    check("p1_point", 32'({score_p1, serve_side, state}), 32'({5'd1, 1'b1, 3'd4}));
    ticks(PAUSE_FRAMES);
    check("p1_no_win_yet", 32'({state, winner}), 32'({3'd2, 2'd0}));
    press_launch();
    miss(1'b0, 1'b1);
    ticks(PAUSE_FRAMES);
    check("p1_wins", 32'({state, winner, score_p1}), 32'({3'd5, 2'd1, 5'd2}));
    miss(1'b1, 1'b0);
    check("miss_ignored", 32'({state, score_p2}), 32'({3'd5, 5'd0}));
    press_launch();
    check("gameover_to_menu", 32'({state, max_score}), 32'({3'd0, 5'd2}));

    // Launch held: exactly one transition
    btn_launch = 1'b1; cyc(1000);
    check("held_launch", 32'(state), 1);
    btn_launch = 1'b0; cyc(1);
    check("held_release", 32'(state), 1);
    press_launch();

    // START with frame ticks and no button
    ticks(SERVE_FRAMES);
`ifdef PONG_AUTO_SERVE_EN
    check("auto_serve", 32'(state), 3);
`else
    check("no_auto_serve", 32'(state), 2);
    press_launch();
`endif

    // Score a point, return to PLAY, reset mid-PLAY
    miss(1'b1, 1'b0);
    ticks(PAUSE_FRAMES);
    press_launch();
    check("p2_one_in_play", 32'({state, score_p2}), 32'({3'd3, 5'd1}));
    pulse_reset();
    check("reset_in_play", 32'({state, score_p1, score_p2, max_score}),
          32'({3'd0, 5'd0, 5'd0, 5'd5}));

    // P2 wins at limit 1
    press_launch();
    press_down(4);
    press_launch();
    press_launch();
    miss(1'b1, 1'b0);
    ticks(PAUSE_FRAMES);
    check("p2_wins", 32'({state, winner, score_p2}), 32'({3'd5, 2'd2, 5'd1}));

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
